// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types and defaults for the IF/ID instruction queue
// Contents: if_id_entry_t {pc, instr}, NOP_INSTR (decode filler), IFQ_DEPTH (default queue depth)
package cpu_pkg;
  localparam int IFQ_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_entry_t;
endpackage

// File: rtl/ifq_ptr_ctrl.sv
// ifq_ptr_ctrl: read/write pointers and occupancy for the IF/ID queue
// Ports: clk, rst (async, active high); flush, push, pop (already qualified by the top);
//        wr_ptr, rd_ptr (wrap modulo DEPTH); count (occupancy); full, empty
module ifq_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push && !flush);
    // a flush abandons everything between the pointers by snapping rd onto wr
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = count_q == CW'(DEPTH);
  assign empty  = count_q == '0;
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: FIFO of {pc_next, instruction} pairs between fetch and decode, NOP when empty
// Ports: clk, rst (async, active high), flush (redirect, empties queue);
//        if_valid/if_pc_next/if_instruction/if_ready (fetch side);
//        id_valid/id_pc_next/id_instruction/id_ready (decode side); count (occupancy)
// Option: define IFQ_BYPASS_EN to pass a fetch pair straight to decode when the queue is empty
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH     = IFQ_DEPTH,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [DATA_W-1:0]        if_pc_next,
  input  logic [DATA_W-1:0]        if_instruction,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [DATA_W-1:0]        id_pc_next,
  output logic [DATA_W-1:0]        id_instruction,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, byp;
  ifq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty)
  );
  // refusing pushes when full even if a pop happens keeps id_ready off the if_ready path
  assign if_ready = !full;
  always_comb begin
    head = mem_q[rd_ptr];
    byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp  = empty && if_valid;
`endif
    id_valid       = !empty || byp;
    id_pc_next     = !empty ? head[2*DATA_W-1:DATA_W] : byp ? if_pc_next : '0;
    id_instruction = !empty ? head[DATA_W-1:0] : byp ? if_instruction : NOP_INSTR;
    pop            = !empty && id_ready && !flush;
    // a bypassed pair that decode takes this cycle is never written
    push           = if_valid && if_ready && !flush && !(byp && id_ready);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= {if_pc_next, if_instruction};
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [31:0] if_pc_next = 0, if_instruction = 0;
  logic if_ready, id_valid;
  logic [31:0] id_pc_next, id_instruction;
  logic [2:0] count;
  int n_cmp = 0, n_err = 0;
  int cnt = 0, nxt = 0;
  logic acc_push;
  logic [63:0] exp_q[$];

  if_id_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc_next(if_pc_next),
    .if_instruction(if_instruction), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc_next(id_pc_next), .id_instruction(id_instruction), .id_ready(id_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one cycle of stimulus and record what the queue must do with it
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic r, input logic f);
    logic byp, acc_pop;
    if_valid = v; if_pc_next = pc; if_instruction = ins; id_ready = r; flush = f;
    acc_push = v && cnt != DEPTH && !f;
    acc_pop  = r && cnt != 0 && !f;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = v && cnt == 0 && r && !f;
`endif
    if (f) exp_q.delete();
    if (acc_push) exp_q.push_back({pc, ins});
    nxt = f ? 0 : cnt + int'(acc_push && !byp) - int'(acc_pop);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cnt = nxt;
    chk("count", 64'(count), 64'(cnt));
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  // monitor: consume the scoreboard whenever decode takes a head entry
  always @(negedge clk) begin
    if (!rst) begin
      chk("count_le_depth", 64'(count <= 3'(DEPTH)), 64'(1));
      if (!id_valid) begin
        chk("nop_instr", 64'(id_instruction), 64'h0);
        chk("nop_pc", 64'(id_pc_next), 64'h0);
      end else if (id_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pop: got %h expected nothing", id_instruction);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("id_instr", 64'(id_instruction), 64'(e[31:0]));
          chk("id_pc", 64'(id_pc_next), 64'(e[63:32]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    rst = 1; if_valid = 1; if_instruction = 32'h11111111;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_if_ready", 64'(if_ready), 64'h1);
    if_valid = 0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'h0);
    chk("rst_id_instr", 64'(id_instruction), 64'h0);
    chk("rst_id_pc", 64'(id_pc_next), 64'h0);
    @(posedge clk); #1; rst = 0;

    drive(1, 32'h4, 32'h8C010004, 0, 0); tick(); idle();
    chk("first_valid", 64'(id_valid), 64'h1);
    chk("first_instr", 64'(id_instruction), 64'h8C010004);
    chk("first_pc", 64'(id_pc_next), 64'h4);
    drive(0, 0, 0, 1, 0); tick();

    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'(i), 0, 0); tick(); idle();
      if (i == 4) chk("full_if_ready", 64'(if_ready), 64'h0);
    end
    chk("refused_count", 64'(count), 64'h4);
    drive(1, 32'h200, 32'h6, 1, 0); tick(); idle();
    chk("full_pop_ready", 64'(if_ready), 64'h1);
    drive(1, 32'h300, 32'hDEADBEEF, 0, 1); tick(); idle();
    chk("flush_valid", 64'(id_valid), 64'h0);
    chk("flush_instr", 64'(id_instruction), 64'h0);
    chk("flush_ready", 64'(if_ready), 64'h1);

    for (int i = 0; i < 4; i++) begin drive(1, 32'h400 + 32'(4 * i), 32'h11 + 32'(i), 0, 0); tick(); end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 1, 0); tick(); idle();
    chk("empty_pop_valid", 64'(id_valid), 64'h0);

    sent = 0;
    for (int c = 0; c < 100 && (sent < 20 || cnt != 0); c++) begin
      drive(sent < 20, 32'h800 + 32'(4 * sent), 32'h1000 + 32'(sent), c[0], 0);
      if (acc_push) sent++;
      tick();
    end
    chk("wrap_sent", 64'(sent), 64'd20);

`ifdef IFQ_BYPASS_EN
    drive(1, 32'h30, 32'h20020005, 1, 0);
    #1;
    chk("byp_valid", 64'(id_valid), 64'h1);
    chk("byp_instr", 64'(id_instruction), 64'h20020005);
    tick();
`endif

    idle(); tick(); tick();
    chk("drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
